// File: rtl/fpu_result_reader.sv
// FIFO buffer for recoded FPU results with exception flags, plus a sticky
// fflags-style accumulator of the flags of every entry the consumer takes.
module fpu_result_reader #(
  parameter int SIZE  = 32,
  parameter int DEPTH = 4,
  localparam int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [SIZE:0]    in_data,
  input  logic [4:0]       in_flags,
  output logic             in_ready,
  output logic             out_valid,
  output logic [SIZE:0]    out_data,
  output logic [4:0]       out_flags,
  input  logic             out_ready,
  output logic [4:0]       flags_acc,
  input  logic             flags_clr,
  output logic [CNT_W-1:0] count
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [SIZE:0]      r_data [DEPTH];
  logic [4:0]         r_flags [DEPTH];
  logic [PTR_W-1:0]   r_wr_ptr;
  logic [PTR_W-1:0]   r_rd_ptr;
  logic [CNT_W-1:0]   r_count;
  logic [4:0]         r_flags_acc;

  logic w_push;
  logic w_pop;

  // Status depends only on registered occupancy, never on out_ready.
  assign in_ready  = (r_count != CNT_W'(DEPTH));
  assign out_valid = (r_count != '0);
  assign out_data  = r_data[r_rd_ptr];
  assign out_flags = r_flags[r_rd_ptr];
  assign flags_acc = r_flags_acc;
  assign count     = r_count;

  assign w_push = in_valid & in_ready;
  assign w_pop  = out_valid & out_ready;

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_entry
      always_ff @(posedge clk) begin
        if (rst) begin
          r_data[gi]  <= '0;
          r_flags[gi] <= '0;
        end else if (w_push && (r_wr_ptr == PTR_W'(gi))) begin
          r_data[gi]  <= in_data;
          r_flags[gi] <= in_flags;
        end
      end
    end
  endgenerate

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Clear takes effect first, so a same-cycle pop seeds the fresh accumulation.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_flags_acc <= '0;
    end else if (flags_clr) begin
      r_flags_acc <= w_pop ? out_flags : 5'b0;
    end else if (w_pop) begin
      r_flags_acc <= r_flags_acc | out_flags;
    end
  end

endmodule

// File: tb/tb_fpu_result_reader.sv
// Scoreboard bench for fpu_result_reader: directed scenarios followed by
// randomized push/pop/clear/reset traffic checked against a queue model.
module tb_fpu_result_reader;

  localparam int SIZE  = 32;
  localparam int DEPTH = 4;
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic [SIZE:0]    in_data;
  logic [4:0]       in_flags;
  logic             in_ready;
  logic             out_valid;
  logic [SIZE:0]    out_data;
  logic [4:0]       out_flags;
  logic             out_ready;
  logic [4:0]       flags_acc;
  logic             flags_clr;
  logic [CNT_W-1:0] count;

  always #5 clk = ~clk;

  fpu_result_reader #(.SIZE(SIZE), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_flags  (in_flags),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_flags (out_flags),
    .out_ready (out_ready),
    .flags_acc (flags_acc),
    .flags_clr (flags_clr),
    .count     (count)
  );

  typedef struct packed {
    logic [SIZE:0] d;
    logic [4:0]    f;
  } ent_t;

  ent_t       exp_q[$];
  logic [4:0] acc_m  = 5'b0;
  bit         mon_en = 1'b0;
  int         vectors = 0;
  int         errors  = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor/model: compares pre-edge DUT state with the queue model, then
  // advances the model by the transfers this edge performs.
  always @(posedge clk) begin
    bit   push_m;
    bit   pop_m;
    ent_t e;
    if (mon_en) begin
      chk("count", 64'(count), 64'(exp_q.size()));
      chk("in_ready", 64'(in_ready), 64'(exp_q.size() != DEPTH));
      chk("out_valid", 64'(out_valid), 64'(exp_q.size() != 0));
      chk("flags_acc", 64'(flags_acc), 64'(acc_m));
      if (out_valid && exp_q.size() != 0) begin
        chk("out_data", 64'(out_data), 64'(exp_q[0].d));
        chk("out_flags", 64'(out_flags), 64'(exp_q[0].f));
      end
    end
    if (rst) begin
      exp_q.delete();
      acc_m = 5'b0;
    end else begin
      push_m = in_valid && (exp_q.size() != DEPTH);
      pop_m  = out_ready && (exp_q.size() != 0);
      if (flags_clr)  acc_m = pop_m ? exp_q[0].f : 5'b0;
      else if (pop_m) acc_m = acc_m | exp_q[0].f;
      if (pop_m) e = exp_q.pop_front();
      if (push_m) exp_q.push_back('{d: in_data, f: in_flags});
    end
  end

  // Drive one cycle of inputs at the falling edge and wait for the next one.
  task automatic cyc(input logic r, input logic iv, input logic [SIZE:0] d,
                     input logic [4:0] f, input logic ordy, input logic clr);
    rst = r; in_valid = iv; in_data = d; in_flags = f; out_ready = ordy; flags_clr = clr;
    @(negedge clk);
  endtask

  initial begin
    logic [SIZE:0] a_data;
    logic [4:0]    a_flags;
    rst = 1'b1; in_valid = 1'b0; in_data = '0; in_flags = '0; out_ready = 1'b0; flags_clr = 1'b0;
    @(negedge clk);
    cyc(1, 0, '0, 5'b0, 0, 0);
    mon_en = 1'b1;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_data", 64'(out_data), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_count", 64'(count), 64'd0);

    // single transfer
    cyc(0, 1, 33'h0_8000_0000, 5'b00001, 0, 0);
    chk("t1_out_valid", 64'(out_valid), 64'd1);
    chk("t1_out_data", 64'(out_data), 64'h0_8000_0000);
    chk("t1_count", 64'(count), 64'd1);
    cyc(0, 0, '0, 5'b0, 1, 0);
    chk("t1_pop_valid", 64'(out_valid), 64'd0);
    chk("t1_pop_count", 64'(count), 64'd0);
    chk("t1_acc", 64'(flags_acc), 64'd1);

    // fill to full, drop while full, then pop releases space
    for (int i = 1; i <= 4; i++) cyc(0, 1, 33'(i), 5'b0, 0, 0);
    chk("t2_count_full", 64'(count), 64'd4);
    chk("t2_in_ready_full", 64'(in_ready), 64'd0);
    cyc(0, 1, 33'd5, 5'b0, 0, 0);
    chk("t2_drop_count", 64'(count), 64'd4);
    cyc(0, 1, 33'd5, 5'b0, 1, 0);
    chk("t2_after_pop_count", 64'(count), 64'd3);
    chk("t2_after_pop_ready", 64'(in_ready), 64'd1);
    cyc(0, 1, 33'd5, 5'b0, 1, 0);
    chk("t2_head_3", 64'(out_data), 64'd3);
    for (int i = 0; i < 4; i++) cyc(0, 0, '0, 5'b0, 1, 0);
    chk("t2_drained", 64'(count), 64'd0);

    // streaming through the pointer wrap
    for (int i = 0; i < 20; i++) begin
      cyc(0, 1, 33'(i), 5'b0, 1, 0);
      chk("t3_count_stream", 64'(count), 64'd1);
    end
    cyc(0, 0, '0, 5'b0, 1, 0);

    // flag accumulation and clear priority
    cyc(0, 0, '0, 5'b0, 0, 1);
    chk("t4_clr0", 64'(flags_acc), 64'd0);
    cyc(0, 1, 33'h11, 5'b00001, 0, 0);
    cyc(0, 1, 33'h22, 5'b00100, 0, 0);
    cyc(0, 1, 33'h33, 5'b10000, 0, 0);
    for (int i = 0; i < 3; i++) cyc(0, 0, '0, 5'b0, 1, 0);
    chk("t4_acc_10101", 64'(flags_acc), 64'b10101);
    cyc(0, 1, 33'h44, 5'b01000, 0, 0);
    cyc(0, 0, '0, 5'b0, 1, 1);
    chk("t4_clr_pop", 64'(flags_acc), 64'b01000);
    cyc(0, 0, '0, 5'b0, 0, 1);
    chk("t4_clr_only", 64'(flags_acc), 64'd0);

    // backpressure: head must hold
    cyc(0, 1, 33'h1_dead_beef, 5'b00110, 0, 0);
    cyc(0, 1, 33'h0_1234_5678, 5'b00001, 0, 0);
    a_data = 33'h1_dead_beef; a_flags = 5'b00110;
    for (int i = 0; i < 10; i++) begin
      cyc(0, 0, '0, 5'b0, 0, 0);
      chk("t5_hold_data", 64'(out_data), 64'(a_data));
      chk("t5_hold_flags", 64'(out_flags), 64'(a_flags));
      chk("t5_hold_count", 64'(count), 64'd2);
    end
    cyc(0, 0, '0, 5'b0, 1, 1);
    cyc(0, 0, '0, 5'b0, 1, 1);

    // reset mid-operation
    cyc(0, 1, 33'h5, 5'b00001, 0, 0);
    cyc(0, 1, 33'h6, 5'b00010, 0, 0);
    cyc(0, 0, '0, 5'b0, 1, 0);
    cyc(0, 0, '0, 5'b0, 1, 0);
    for (int i = 0; i < 3; i++) cyc(0, 1, 33'(100 + i), 5'b11111, 0, 0);
    chk("t6_pre_acc", 64'(flags_acc), 64'b00011);
    chk("t6_pre_count", 64'(count), 64'd3);
    cyc(1, 1, 33'h7, 5'b11111, 1, 0);
    chk("t6_count", 64'(count), 64'd0);
    chk("t6_out_valid", 64'(out_valid), 64'd0);
    chk("t6_out_data", 64'(out_data), 64'd0);
    chk("t6_acc", 64'(flags_acc), 64'd0);
    chk("t6_in_ready", 64'(in_ready), 64'd1);

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      cyc(($urandom_range(0, 99) == 0), ($urandom_range(0, 2) != 0),
          {1'($urandom), 32'($urandom)}, 5'($urandom),
          ($urandom_range(0, 2) != 0), ($urandom_range(0, 9) == 0));
    end
    for (int i = 0; i < DEPTH + 1; i++) cyc(0, 0, '0, 5'b0, 1, 0);
    chk("final_empty", 64'(count), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
